// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer plus 16x-oversampled frame FSM with a framing error flag.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data and the parity_err_o port.
module uart_rx #(
  parameter int unsigned DataBits = 8,
  parameter int unsigned SbTicks  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  input  logic                s_tick_i,
  output logic [DataBits-1:0] dout_o,
  output logic                rx_done_tick_o,
  output logic                frame_err_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                parity_err_o
`endif
);

  localparam int unsigned NW = (DataBits > 1) ? $clog2(DataBits) : 1;
  localparam int unsigned SW = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic                rx_meta;
  logic                rx_s;
  state_t              state,   state_n;
  logic [SW-1:0]       s_cnt,   s_cnt_n;
  logic [NW-1:0]       n_cnt,   n_cnt_n;
  logic [DataBits-1:0] b_reg,   b_reg_n;
  logic [DataBits-1:0] dout_n;
  logic                done_n;
  logic                ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                par_bit, par_bit_n;
  logic                perr_n;
`endif

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      s_cnt          <= '0;
      n_cnt          <= '0;
      b_reg          <= '0;
      dout_o         <= '0;
      rx_done_tick_o <= 1'b0;
      frame_err_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit        <= 1'b0;
      parity_err_o   <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      s_cnt          <= s_cnt_n;
      n_cnt          <= n_cnt_n;
      b_reg          <= b_reg_n;
      dout_o         <= dout_n;
      rx_done_tick_o <= done_n;
      frame_err_o    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bit        <= par_bit_n;
      parity_err_o   <= perr_n;
`endif
    end
  end

  // Next-state logic; the tick that completes a phase is consumed by the transition
  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    b_reg_n = b_reg;
    dout_n  = dout_o;
    done_n  = 1'b0;
    ferr_n  = frame_err_o;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
    perr_n    = parity_err_o;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (s_tick_i) begin
          if (s_cnt == SW'(7)) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick_i) begin
          if (s_cnt == SW'(15)) begin
            b_reg_n = {rx_s, b_reg[DataBits-1:1]};
            s_cnt_n = '0;
            if (n_cnt == NW'(DataBits - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_cnt_n = n_cnt + NW'(1);
            end
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick_i) begin
          if (s_cnt == SW'(15)) begin
            par_bit_n = rx_s;
            s_cnt_n   = '0;
            state_n   = STOP;
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick_i) begin
          if (s_cnt == SW'(SbTicks - 1)) begin
            dout_n  = b_reg;
            ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_n  = (^b_reg) ^ par_bit;
`endif
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_cnt_n = s_cnt + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frame bench for uart_rx; expected results come from the frame contents.
module tb_uart_rx;

  localparam int unsigned BitClks = 64;  // 16 ticks per bit, one tick every 4 clocks

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       done;
  logic       ferr;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  uart_rx #(.DataBits(8), .SbTicks(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_i           (rx),
    .s_tick_i       (s_tick),
    .dout_o         (dout),
    .rx_done_tick_o (done),
    .frame_err_o    (ferr)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o   (perr)
`endif
  );

  always #5 clk = ~clk;

  int unsigned tick_div = 0;
  always @(posedge clk) begin
    tick_div <= (tick_div + 1) % 4;
    s_tick   <= (tick_div == 3);
  end

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int wide_strobes = 0;
  int exp_strobes = 0;
  logic prev_done = 1'b0;

  // Strobe monitor sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      strobes++;
      if (prev_done === 1'b1) wide_strobes++;
    end
    prev_done = done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int unsigned clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // A low stop bit is held only 3/4 of a bit so the line is high again before any re-sampled start
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input int unsigned idle_clks);
    hold(1'b0, BitClks);
    for (int i = 0; i < 8; i++) hold(d[i], BitClks);
`ifdef UART_RX_PARITY_EN
    hold(par, BitClks);
`else
    if (par === 1'bx) hold(1'b1, 0);
`endif
    if (stop) hold(1'b1, BitClks);
    else begin
      hold(1'b0, 48);
      hold(1'b1, 16);
    end
    hold(1'b1, idle_clks);
  endtask

  // Reference model: one strobe per frame, data as sent, error flags from the frame's own bits
  task automatic xfer(input string tag, input logic [7:0] d, input logic stop, input logic par,
                      input int unsigned idle_clks);
    logic exp_ferr;
    logic exp_perr;
    exp_ferr = (stop == 1'b0);
    exp_perr = ((($countones(d) + int'(par)) % 2) != 0);
    send_frame(d, stop, par, idle_clks);
    exp_strobes++;
    check({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
    check({tag, "_dout"}, 32'(dout), 32'(d));
    check({tag, "_ferr"}, 32'(ferr), 32'(exp_ferr));
`ifdef UART_RX_PARITY_EN
    check({tag, "_perr"}, 32'(perr), 32'(exp_perr));
`else
    if (exp_perr === 1'bx) check({tag, "_perr_x"}, 32'(ferr), 32'(exp_ferr));
`endif
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
`ifdef UART_RX_PARITY_EN
    check("reset_perr", 32'(perr), 32'h0);
`endif
    hold(1'b1, BitClks);

    xfer("a5", 8'hA5, 1'b1, 1'b0, 0);
    xfer("3c_badstop", 8'h3C, 1'b0, 1'b0, BitClks);
    xfer("01", 8'h01, 1'b1, 1'b1, 0);

    // Short low glitch is rejected at the start-bit midpoint
    hold(1'b0, 12);
    hold(1'b1, 2 * BitClks);
    check("glitch_strobes", 32'(strobes), 32'(exp_strobes));
    check("glitch_dout", 32'(dout), 32'h01);
    xfer("5a", 8'h5A, 1'b1, 1'b0, 0);

    xfer("b2b_00", 8'h00, 1'b1, 1'b0, 0);
    xfer("b2b_ff", 8'hFF, 1'b1, 1'b0, 0);

    // Reset in the middle of data bit 4 of 0xF5 aborts the frame
    d = 8'hF5;
    hold(1'b0, BitClks);
    for (int i = 0; i < 4; i++) hold(d[i], BitClks);
    hold(d[4], BitClks / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_dout", 32'(dout), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_ferr", 32'(ferr), 32'h0);
    hold(1'b1, 10 * BitClks);
    check("midrst_strobes", 32'(strobes), 32'(exp_strobes));
    xfer("81", 8'h81, 1'b1, 1'b0, 0);

`ifdef UART_RX_PARITY_EN
    xfer("07_par0", 8'h07, 1'b1, 1'b0, 0);
    check("07_par0_perr_set", 32'(perr), 32'h1);
    xfer("07_par1", 8'h07, 1'b1, 1'b1, 0);
    check("07_par1_perr_clr", 32'(perr), 32'h0);
`endif

    for (int k = 0; k < 8; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = 1'($urandom);
      xfer($sformatf("rand%0d", k), d, stop, par, stop ? 0 : BitClks);
    end

    hold(1'b1, 2 * BitClks);
    check("final_strobes", 32'(strobes), 32'(exp_strobes));
    check("strobe_width", 32'(wide_strobes), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive path: recovers asynchronous 8N1-style serial frames from `rx_i` using a 16x oversampling tick from the existing `mod_m_counter` baud generator, and presents each received byte with a one-cycle completion strobe. It is the receiving end of the RS-232 link and pairs with the transmitter on the same tick source. A framing error flag is always reported. Parity checking is optional.

## Interface
- `DataBits`, 8: data bits per frame, LSB first.
- `SbTicks`, 16: oversampling ticks spent in the stop bit (16 = 1, 24 = 1.5, 32 = 2 stop bits).
- `clk_i` input 1: system clock; single clock domain.
- `rst_i` input 1: reset, synchronous, active-high.
- `rx_i` input 1: asynchronous serial line; idles high.
- `s_tick_i` input 1: one-`clk_i` pulse at 16x baud rate.
- `dout_o` output `DataBits`: last received data word.
- `rx_done_tick_o` output 1: one-cycle strobe marking frame completion.
- `frame_err_o` output 1: the last frame's stop bit was sampled low.
- `parity_err_o` output 1: the last frame's parity mismatched. Present only with `UART_RX_PARITY_EN`.

## Operation
- `rx_i` passes through a 2-flop synchronizer; both flops reset to 1. All FSM decisions use the synchronized value `rx_s`.
- **Counters:**
  - `s_cnt` is 6 bits wide; it advances only on `s_tick_i` and holds otherwise.
  - `n_cnt` is the bit index, width clog2(`DataBits`).
  - `b_reg` is the shift register.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP.
- **IDLE:** when `rx_s` = 0, go to START and clear `s_cnt`. Ticks are ignored in IDLE.
- **START:**
  - On a tick with `s_cnt` = 7 (start-bit midpoint): if `rx_s` = 0, go to DATA and clear `s_cnt` and `n_cnt`.
  - If `rx_s` = 1 at that point, return to IDLE with no strobe and no error (glitch rejection).
  - Otherwise, increment `s_cnt` on each tick.
- **DATA:**
  - On a tick with `s_cnt` = 15: load `b_reg` <= {`rx_s`, `b_reg[DataBits-1:1]`} and clear `s_cnt`.
  - If `n_cnt` = `DataBits`-1, go to PARITY (macro) or STOP; otherwise increment `n_cnt`.
- **PARITY:** on a tick with `s_cnt` = 15, capture `rx_s` as the parity bit, clear `s_cnt`, and go to STOP.
- **STOP:** on a tick with `s_cnt` = `SbTicks`-1:
  - Register `dout_o` <= `b_reg` and `frame_err_o` <= ~`rx_s`.
  - With the macro, also register `parity_err_o`.
  - Pulse `rx_done_tick_o` and go to IDLE.
- A frame with a bad stop bit still updates `dout_o` and still pulses `rx_done_tick_o`.
- `dout_o` and the error flags hold their values until the next completion strobe; they never change mid-frame.
- `rx_i` held low indefinitely: after a frame completes with `frame_err_o` = 1, the FSM re-enters START immediately. There is no break detection.
- **Reset values:** state IDLE, `dout_o` = 0, `rx_done_tick_o` = 0, `frame_err_o` = 0, `parity_err_o` = 0, `s_cnt` = `n_cnt` = `b_reg` = 0.
- Reset asserted mid-frame aborts the frame without a strobe, and all outputs return to their reset values on the next edge.

## Timing
- The synchronizer adds 2 `clk_i` cycles from an `rx_i` edge to `rx_s`.
- `rx_done_tick_o` is high for exactly one `clk_i` cycle: the cycle after the edge that consumes the final STOP tick. `dout_o`, `frame_err_o` and `parity_err_o` become valid in that same cycle.
- Each data bit is sampled 16 ticks after the previous one, starting 16 ticks after the start-bit midpoint.
- Frame length from the falling edge is about 8 + 16·`DataBits` (+16 with parity) + `SbTicks` ticks.
- `s_tick_i` coincident with a state transition is consumed by the transition and is not double-counted.
- `s_tick_i` held high for consecutive cycles counts one tick per cycle.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state and `parity_err_o` port exist.
  - Parity is even: `parity_err_o` = (^`b_reg`) ^ parity bit.
- Not defined:
  - No PARITY state and no `parity_err_o` port.
  - DATA goes directly to STOP.

## Test plan
- `s_tick_i` every 4 clocks; send 0xA5 with stop = 1 -> a single `rx_done_tick_o` pulse, `dout_o` = 0xA5, `frame_err_o` = 0.
- Send 0x3C with stop bit = 0 -> strobe asserts, `dout_o` = 0x3C, `frame_err_o` = 1. A following good 0x01 frame -> `frame_err_o` = 0.
- Low pulse on `rx_i` lasting 3 ticks -> no strobe, FSM back in IDLE. A following 0x5A frame is received correctly.
- Back-to-back 0x00 then 0xFF with one stop bit each -> two strobes, `dout_o` = 0x00 then 0xFF, no errors.
- Assert `rst_i` for 1 cycle during data bit 4 -> all outputs 0, no strobe for the aborted frame. Next frame 0x81 -> `dout_o` = 0x81.
- Macro on: send 0x07 with parity bit 0 -> `parity_err_o` = 1. Send 0x07 with parity bit 1 -> `parity_err_o` = 0.
